sim_mem_bridge: RTL and testbench

//  Valid/ready front end for SimMem, the DPI-backed simulation memory. Sits between
//  the core's instruction-fetch and load/store units (upstream) and SimMem (downstream).

---
 rtl/sim_mem_bridge_if.sv | 51 +++++
 rtl/sim_mem_bridge.sv | 158 +++++++++++++++
 tb/tb_sim_mem_bridge.sv | 401 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sim_mem_bridge_if.sv
// Fetch and load/store valid/ready channels plus the SimMem port of sim_mem_bridge.
// The bridge takes the slave view; the core and SimMem together take the master view.
interface sim_mem_bridge_if #(
    parameter int unsigned XLEN = 64
);
    logic            imem_req_valid;
    logic            imem_req_ready;
    logic [XLEN-1:0] imem_req_addr;
    logic            imem_resp_valid;
    logic            imem_resp_ready;
    logic [31:0]     imem_resp_data;
    logic            imem_resp_err;

    logic            dmem_req_valid;
    logic            dmem_req_ready;
    logic [XLEN-1:0] dmem_req_addr;
    logic [XLEN-1:0] dmem_req_wdata;
    logic [1:0]      dmem_req_size;
    logic            dmem_req_wen;
    logic            dmem_resp_valid;
    logic            dmem_resp_ready;
    logic [XLEN-1:0] dmem_resp_rdata;
    logic            dmem_resp_err;

    logic [XLEN-1:0] sim_iaddr;
    logic [XLEN-1:0] sim_imask;
    logic [XLEN-1:0] sim_idata;
    logic [XLEN-1:0] sim_daddr;
    logic [XLEN-1:0] sim_dwdata;
    logic [XLEN-1:0] sim_dmask;
    logic [XLEN-1:0] sim_drdata;
    logic            sim_dwen;

    modport master (
        output imem_req_valid, imem_req_addr, imem_resp_ready,
        output dmem_req_valid, dmem_req_addr, dmem_req_wdata, dmem_req_size, dmem_req_wen,
        output dmem_resp_ready, sim_idata, sim_drdata,
        input  imem_req_ready, imem_resp_valid, imem_resp_data, imem_resp_err,
        input  dmem_req_ready, dmem_resp_valid, dmem_resp_rdata, dmem_resp_err,
        input  sim_iaddr, sim_imask, sim_daddr, sim_dwdata, sim_dmask, sim_dwen
    );

    modport slave (
        input  imem_req_valid, imem_req_addr, imem_resp_ready,
        input  dmem_req_valid, dmem_req_addr, dmem_req_wdata, dmem_req_size, dmem_req_wen,
        input  dmem_resp_ready, sim_idata, sim_drdata,
        output imem_req_ready, imem_resp_valid, imem_resp_data, imem_resp_err,
        output dmem_req_ready, dmem_resp_valid, dmem_resp_rdata, dmem_resp_err,
        output sim_iaddr, sim_imask, sim_daddr, sim_dwdata, sim_dmask, sim_dwen
    );
endinterface

// File: rtl/sim_mem_bridge.sv
// Valid/ready front end for the SimMem simulation memory: one independent FSM per channel
// turns each request into a single-edge SimMem access, captures the data and responds.
module sim_mem_bridge #(
    parameter int unsigned XLEN    = 64,
    parameter int unsigned LATENCY = 0
) (
    input logic             clk,
    input logic             reset_n,
    sim_mem_bridge_if.slave bus
);
    typedef enum logic [2:0] {StIdle, StAccess, StCapture, StDelay, StResp} state_e;

    localparam logic [3:0] DelayInit = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

    function automatic state_e fsm_next(state_e st, logic req_fire, logic cnt_zero,
                                        logic resp_ready);
        fsm_next = st;
        case (st)
            StIdle:    if (req_fire) fsm_next = StAccess;
            StAccess:  fsm_next = StCapture;
            StCapture: fsm_next = (LATENCY > 0) ? StDelay : StResp;
            StDelay:   if (cnt_zero) fsm_next = StResp;
            StResp:    if (resp_ready) fsm_next = StIdle;
            default:   fsm_next = StIdle;
        endcase
    endfunction

    function automatic logic d_misaligned(logic [2:0] off, logic [1:0] size);
        case (size)
            2'd0:    d_misaligned = 1'b0;
            2'd1:    d_misaligned = off[0];
            2'd2:    d_misaligned = |off[1:0];
            default: d_misaligned = |off;
        endcase
    endfunction

    // ---------------- imem channel ----------------
    state_e          r_i_state;
    state_e          w_i_state_next;
    logic [XLEN-1:0] r_i_addr;
    logic            r_i_err;
    logic [31:0]     r_i_data;
    logic [3:0]      r_i_cnt;
    logic            w_i_req_fire;

    always_comb begin
        w_i_req_fire   = bus.imem_req_valid && (r_i_state == StIdle);
        w_i_state_next = fsm_next(r_i_state, w_i_req_fire, r_i_cnt == 4'd0,
                                  bus.imem_resp_ready);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_i_state <= StIdle;
            r_i_addr  <= '0;
            r_i_err   <= 1'b0;
            r_i_data  <= '0;
            r_i_cnt   <= '0;
        end else begin
            r_i_state <= w_i_state_next;
            if (w_i_req_fire) begin
                r_i_addr <= bus.imem_req_addr;
                r_i_err  <= |bus.imem_req_addr[1:0];
            end
            if (r_i_state == StCapture) begin
                r_i_data <= r_i_err ? 32'd0
                          : (r_i_addr[2] ? bus.sim_idata[63:32] : bus.sim_idata[31:0]);
            end
            if (r_i_state == StCapture) begin
                r_i_cnt <= DelayInit;
            end else if (r_i_state == StDelay && r_i_cnt != 4'd0) begin
                r_i_cnt <= r_i_cnt - 4'd1;
            end
        end
    end

    always_comb begin
        // Idle state is forced by reset, so ready is masked by reset_n itself
        bus.imem_req_ready  = reset_n && (r_i_state == StIdle);
        bus.imem_resp_valid = (r_i_state == StResp);
        bus.imem_resp_data  = (r_i_state == StResp) ? r_i_data : 32'd0;
        bus.imem_resp_err   = (r_i_state == StResp) && r_i_err;
        bus.sim_iaddr       = {r_i_addr[XLEN-1:3], 3'b000};
        bus.sim_imask       = (r_i_state == StAccess && !r_i_err) ? '1 : '0;
    end

    // ---------------- dmem channel ----------------
    state_e          r_d_state;
    state_e          w_d_state_next;
    logic [XLEN-1:0] r_d_addr;
    logic [XLEN-1:0] r_d_wdata;
    logic [XLEN-1:0] r_d_rdata;
    logic [1:0]      r_d_size;
    logic            r_d_wen;
    logic            r_d_err;
    logic [3:0]      r_d_cnt;
    logic            w_d_req_fire;
    logic            w_d_access;
    logic [5:0]      w_d_shamt;
    logic [XLEN-1:0] w_d_size_mask;

    always_comb begin
        w_d_req_fire = bus.dmem_req_valid && (r_d_state == StIdle);
        w_d_shamt    = {r_d_addr[2:0], 3'b000};
        case (r_d_size)
            2'd0:    w_d_size_mask = 64'h0000_0000_0000_00FF;
            2'd1:    w_d_size_mask = 64'h0000_0000_0000_FFFF;
            2'd2:    w_d_size_mask = 64'h0000_0000_FFFF_FFFF;
            default: w_d_size_mask = '1;
        endcase
        w_d_access     = (r_d_state == StAccess) && !r_d_err;
        w_d_state_next = fsm_next(r_d_state, w_d_req_fire, r_d_cnt == 4'd0,
                                  bus.dmem_resp_ready);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_d_state <= StIdle;
            r_d_addr  <= '0;
            r_d_wdata <= '0;
            r_d_rdata <= '0;
            r_d_size  <= '0;
            r_d_wen   <= 1'b0;
            r_d_err   <= 1'b0;
            r_d_cnt   <= '0;
        end else begin
            r_d_state <= w_d_state_next;
            if (w_d_req_fire) begin
                r_d_addr  <= bus.dmem_req_addr;
                r_d_wdata <= bus.dmem_req_wdata;
                r_d_size  <= bus.dmem_req_size;
                r_d_wen   <= bus.dmem_req_wen;
                r_d_err   <= d_misaligned(bus.dmem_req_addr[2:0], bus.dmem_req_size);
            end
            if (r_d_state == StCapture) begin
                r_d_rdata <= (r_d_err || r_d_wen) ? '0
                           : (bus.sim_drdata >> w_d_shamt) & w_d_size_mask;
            end
            if (r_d_state == StCapture) begin
                r_d_cnt <= DelayInit;
            end else if (r_d_state == StDelay && r_d_cnt != 4'd0) begin
                r_d_cnt <= r_d_cnt - 4'd1;
            end
        end
    end

    always_comb begin
        bus.dmem_req_ready  = reset_n && (r_d_state == StIdle);
        bus.dmem_resp_valid = (r_d_state == StResp);
        bus.dmem_resp_rdata = (r_d_state == StResp) ? r_d_rdata : '0;
        bus.dmem_resp_err   = (r_d_state == StResp) && r_d_err;
        bus.sim_daddr       = {r_d_addr[XLEN-1:3], 3'b000};
        bus.sim_dwdata      = r_d_wdata << w_d_shamt;
        // Masks and write enable exist only in the single access cycle
        bus.sim_dmask       = w_d_access ? (w_d_size_mask << w_d_shamt) : '0;
        bus.sim_dwen        = w_d_access && r_d_wen;
    end
endmodule

// File: tb/tb_sim_mem_bridge.sv
// Self-checking bench for sim_mem_bridge: one LATENCY=0 and one LATENCY=3 instance, each
// backed by a small SimMem model, with expected responses queued per channel.
module tb_sim_mem_bridge;
    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    sim_mem_bridge_if #(.XLEN(64)) b0 ();
    sim_mem_bridge_if #(.XLEN(64)) b3 ();

    sim_mem_bridge #(.XLEN(64), .LATENCY(0)) u_dut0 (.clk(clk), .reset_n(reset_n), .bus(b0.slave));
    sim_mem_bridge #(.XLEN(64), .LATENCY(3)) u_dut3 (.clk(clk), .reset_n(reset_n), .bus(b3.slave));

    int n_assert = 0;
    int n_fail   = 0;

    logic [63:0] mem0 [0:63];
    logic [63:0] mem3 [0:63];
    logic [64:0] exp_d [$];
    logic [32:0] exp_i [$];

    // SimMem model: port sampled mid-cycle, access executed at the following posedge
    logic [63:0] s0_iaddr = '0, s0_imask = '0, s0_daddr = '0, s0_dmask = '0, s0_dwdata = '0;
    logic [63:0] s3_daddr = '0, s3_dmask = '0, s3_dwdata = '0;
    logic        s0_dwen = 1'b0, s3_dwen = 1'b0;

    always @(negedge clk) begin
        s0_iaddr  <= b0.sim_iaddr;
        s0_imask  <= b0.sim_imask;
        s0_daddr  <= b0.sim_daddr;
        s0_dmask  <= b0.sim_dmask;
        s0_dwdata <= b0.sim_dwdata;
        s0_dwen   <= b0.sim_dwen;
        s3_daddr  <= b3.sim_daddr;
        s3_dmask  <= b3.sim_dmask;
        s3_dwdata <= b3.sim_dwdata;
        s3_dwen   <= b3.sim_dwen;
    end

    always @(posedge clk) begin
        if (s0_imask != '0) b0.sim_idata <= mem0[s0_iaddr[8:3]];
        if (s0_dmask != '0) begin
            b0.sim_drdata <= mem0[s0_daddr[8:3]];
            if (s0_dwen)
                mem0[s0_daddr[8:3]] <= (mem0[s0_daddr[8:3]] & ~s0_dmask) | (s0_dwdata & s0_dmask);
        end
        if (s3_dmask != '0) begin
            b3.sim_drdata <= mem3[s3_daddr[8:3]];
            if (s3_dwen)
                mem3[s3_daddr[8:3]] <= (mem3[s3_daddr[8:3]] & ~s3_dmask) | (s3_dwdata & s3_dmask);
        end
    end

    int          dwen_cnt0 = 0, dmask_cnt0 = 0, overlap_cnt0 = 0;
    logic [63:0] last_dmask0 = '0, last_dwdata0 = '0;

    always @(negedge clk) begin
        if (b0.sim_dwen) dwen_cnt0 <= dwen_cnt0 + 1;
        if (b0.sim_dmask != '0) begin
            dmask_cnt0   <= dmask_cnt0 + 1;
            last_dmask0  <= b0.sim_dmask;
            last_dwdata0 <= b0.sim_dwdata;
        end
        if (b0.sim_dmask != '0 && b0.sim_imask != '0) overlap_cnt0 <= overlap_cnt0 + 1;
    end

    task automatic d_send(input logic [63:0] a, input logic [63:0] wd, input logic [1:0] sz,
                          input logic we);
        int n = 0;
        @(negedge clk);
        b0.dmem_req_addr  = a;
        b0.dmem_req_wdata = wd;
        b0.dmem_req_size  = sz;
        b0.dmem_req_wen   = we;
        b0.dmem_req_valid = 1'b1;
        while (!b0.dmem_req_ready && n < 20) begin @(negedge clk); n++; end
        if (!b0.dmem_req_ready) begin
            n_assert++; n_fail++;
            $display("FAIL d_send_timeout addr=%h ready never seen", a);
        end
        @(posedge clk); #1;
        b0.dmem_req_valid = 1'b0;
    endtask

    task automatic d_recv(output logic [64:0] got, output int lat);
        int k = 0;
        do begin @(negedge clk); k++; end while (!b0.dmem_resp_valid && k < 40);
        got = {b0.dmem_resp_err, b0.dmem_resp_rdata};
        lat = k - 1;
        if (!b0.dmem_resp_valid) begin
            n_assert++; n_fail++;
            $display("FAIL d_recv_timeout got no resp_valid within %0d cycles", k);
        end else begin
            @(posedge clk); #1;
        end
    endtask

    task automatic i_send(input logic [63:0] a);
        int n = 0;
        @(negedge clk);
        b0.imem_req_addr  = a;
        b0.imem_req_valid = 1'b1;
        while (!b0.imem_req_ready && n < 20) begin @(negedge clk); n++; end
        if (!b0.imem_req_ready) begin
            n_assert++; n_fail++;
            $display("FAIL i_send_timeout addr=%h ready never seen", a);
        end
        @(posedge clk); #1;
        b0.imem_req_valid = 1'b0;
    endtask

    task automatic i_recv(output logic [32:0] got, output int lat);
        int k = 0;
        do begin @(negedge clk); k++; end while (!b0.imem_resp_valid && k < 40);
        got = {b0.imem_resp_err, b0.imem_resp_data};
        lat = k - 1;
        if (!b0.imem_resp_valid) begin
            n_assert++; n_fail++;
            $display("FAIL i_recv_timeout got no resp_valid within %0d cycles", k);
        end else begin
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        n_assert++;
        if ({b0.dmem_req_ready, b0.imem_req_ready, b3.dmem_req_ready} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_req_ready got %b expected 000",
                     {b0.dmem_req_ready, b0.imem_req_ready, b3.dmem_req_ready});
        end
        n_assert++;
        if ({b0.dmem_resp_valid, b0.imem_resp_valid, b0.sim_dwen, b0.sim_dmask, b0.sim_imask,
             b0.dmem_resp_rdata, b0.sim_daddr} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs got dmask=%h imask=%h dwen=%b rdata=%h expected all 0",
                     b0.sim_dmask, b0.sim_imask, b0.sim_dwen, b0.dmem_resp_rdata);
        end
        reset_n = 1'b1;
        #1;
        n_assert++;
        if ({b0.dmem_req_ready, b0.imem_req_ready, b3.dmem_req_ready} !== 3'b111) begin
            n_fail++;
            $display("FAIL release_req_ready got %b expected 111",
                     {b0.dmem_req_ready, b0.imem_req_ready, b3.dmem_req_ready});
        end
    endtask

    task automatic test_store_load();
        logic [64:0] got, e;
        int lat;
        int c = dwen_cnt0;
        d_send(64'h8000_0008, 64'h1122_3344_5566_7788, 2'd3, 1'b1);
        exp_d.push_back({1'b0, 64'd0});
        d_recv(got, lat);
        e = exp_d.pop_front();
        n_assert++;
        if (got !== e) begin n_fail++; $display("FAIL store_resp got %h expected %h", got, e); end
        n_assert++;
        if (dwen_cnt0 - c !== 1) begin
            n_fail++; $display("FAIL dwen_cycles got %0d expected 1", dwen_cnt0 - c);
        end
        d_send(64'h8000_0008, 64'd0, 2'd3, 1'b0);
        exp_d.push_back({1'b0, 64'h1122_3344_5566_7788});
        d_recv(got, lat);
        e = exp_d.pop_front();
        n_assert++;
        if (got !== e) begin n_fail++; $display("FAIL load_dword got %h expected %h", got, e); end
        n_assert++;
        if (lat !== 2) begin n_fail++; $display("FAIL load_latency got %0d expected 2", lat); end
    endtask

    task automatic test_byte_store();
        logic [64:0] got, e;
        int lat;
        d_send(64'h8000_0010, 64'd0, 2'd3, 1'b1);
        exp_d.push_back({1'b0, 64'd0});
        d_recv(got, lat);
        e = exp_d.pop_front();
        n_assert++;
        if (got !== e) begin n_fail++; $display("FAIL zero_store got %h expected %h", got, e); end
        d_send(64'h8000_0013, 64'h0000_0000_0000_00AB, 2'd0, 1'b1);
        exp_d.push_back({1'b0, 64'd0});
        d_recv(got, lat);
        e = exp_d.pop_front();
        n_assert++;
        if (last_dmask0 !== 64'h0000_0000_FF00_0000) begin
            n_fail++; $display("FAIL byte_dmask got %h expected 00000000ff000000", last_dmask0);
        end
        n_assert++;
        if (last_dwdata0 !== 64'h0000_0000_AB00_0000) begin
            n_fail++; $display("FAIL byte_dwdata got %h expected 00000000ab000000", last_dwdata0);
        end
        d_send(64'h8000_0010, 64'd0, 2'd3, 1'b0);
        exp_d.push_back({1'b0, 64'h0000_0000_AB00_0000});
        d_recv(got, lat);
        e = exp_d.pop_front();
        n_assert++;
        if (got !== e) begin n_fail++; $display("FAIL byte_reload got %h expected %h", got, e); end
        d_send(64'h8000_0013, 64'd0, 2'd0, 1'b0);
        exp_d.push_back({1'b0, 64'h0000_0000_0000_00AB});
        d_recv(got, lat);
        e = exp_d.pop_front();
        n_assert++;
        if (got !== e) begin n_fail++; $display("FAIL byte_load got %h expected %h", got, e); end
    endtask

    task automatic test_misaligned();
        logic [64:0] got, e;
        int lat;
        int cm = dmask_cnt0;
        int cw = dwen_cnt0;
        d_send(64'h8000_0001, 64'd0, 2'd1, 1'b0);
        exp_d.push_back({1'b1, 64'd0});
        d_recv(got, lat);
        e = exp_d.pop_front();
        n_assert++;
        if (got !== e) begin n_fail++; $display("FAIL misaligned_half got %h expected %h", got, e); end
        n_assert++;
        if (lat !== 2) begin n_fail++; $display("FAIL misaligned_latency got %0d expected 2", lat); end
        d_send(64'h8000_0012, 64'hFFFF_FFFF, 2'd2, 1'b1);
        exp_d.push_back({1'b1, 64'd0});
        d_recv(got, lat);
        e = exp_d.pop_front();
        n_assert++;
        if (got !== e) begin n_fail++; $display("FAIL misaligned_store got %h expected %h", got, e); end
        n_assert++;
        if ((dmask_cnt0 - cm) !== 0 || (dwen_cnt0 - cw) !== 0) begin
            n_fail++;
            $display("FAIL misaligned_no_access got mask_cycles=%0d dwen_cycles=%0d expected 0 0",
                     dmask_cnt0 - cm, dwen_cnt0 - cw);
        end
        n_assert++;
        if (mem0[2] !== 64'h0000_0000_AB00_0000) begin
            n_fail++; $display("FAIL misaligned_mem got %h expected 00000000ab000000", mem0[2]);
        end
    endtask

    task automatic test_concurrent();
        logic [32:0] ig, ie;
        logic [64:0] dg, de;
        int il, dl;
        int ov = overlap_cnt0;
        fork
            begin
                i_send(64'h8000_0000);
                exp_i.push_back({1'b0, 32'hDEAD_BEEF});
                i_recv(ig, il);
                ie = exp_i.pop_front();
                n_assert++;
                if (ig !== ie) begin n_fail++; $display("FAIL fetch_low got %h expected %h", ig, ie); end
                n_assert++;
                if (il !== 2) begin n_fail++; $display("FAIL fetch_latency got %0d expected 2", il); end
                i_send(64'h8000_0004);
                exp_i.push_back({1'b0, 32'hCAFE_BABE});
                i_recv(ig, il);
                ie = exp_i.pop_front();
                n_assert++;
                if (ig !== ie) begin n_fail++; $display("FAIL fetch_high got %h expected %h", ig, ie); end
                i_send(64'h8000_0002);
                exp_i.push_back({1'b1, 32'd0});
                i_recv(ig, il);
                ie = exp_i.pop_front();
                n_assert++;
                if (ig !== ie) begin n_fail++; $display("FAIL fetch_misaligned got %h expected %h", ig, ie); end
            end
            begin
                d_send(64'h8000_0008, 64'd0, 2'd3, 1'b0);
                exp_d.push_back({1'b0, 64'h1122_3344_5566_7788});
                d_recv(dg, dl);
                de = exp_d.pop_front();
                n_assert++;
                if (dg !== de) begin n_fail++; $display("FAIL conc_load got %h expected %h", dg, de); end
                d_send(64'h8000_001A, 64'h0000_0000_0000_BEEF, 2'd1, 1'b1);
                exp_d.push_back({1'b0, 64'd0});
                d_recv(dg, dl);
                de = exp_d.pop_front();
                d_send(64'h8000_0018, 64'd0, 2'd2, 1'b0);
                exp_d.push_back({1'b0, 64'h0000_0000_BEEF_0000});
                d_recv(dg, dl);
                de = exp_d.pop_front();
                n_assert++;
                if (dg !== de) begin n_fail++; $display("FAIL conc_half_reload got %h expected %h", dg, de); end
            end
        join
        n_assert++;
        if (!(overlap_cnt0 > ov)) begin
            n_fail++; $display("FAIL concurrent_access got overlap cycles %0d expected >0", overlap_cnt0 - ov);
        end
    endtask

    task automatic test_latency();
        logic [64:0] e, got;
        int k = 0;
        b3.dmem_resp_ready = 1'b0;
        @(negedge clk);
        b3.dmem_req_addr  = 64'h8000_0104;
        b3.dmem_req_wdata = 64'd0;
        b3.dmem_req_size  = 2'd2;
        b3.dmem_req_wen   = 1'b0;
        b3.dmem_req_valid = 1'b1;
        exp_d.push_back({1'b0, 64'h0000_0000_0123_4567});
        @(posedge clk); #1;
        b3.dmem_req_valid = 1'b0;
        e = exp_d.pop_front();
        do begin @(negedge clk); k++; end while (!b3.dmem_resp_valid && k < 40);
        n_assert++;
        if (k - 1 !== 5) begin n_fail++; $display("FAIL lat3_latency got %0d expected 5", k - 1); end
        for (int c = 0; c < 5; c++) begin
            got = {b3.dmem_resp_err, b3.dmem_resp_rdata};
            n_assert++;
            if (got !== e || b3.dmem_resp_valid !== 1'b1 || b3.dmem_req_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL lat3_hold cycle %0d got data=%h valid=%b req_ready=%b expected %h 1 0",
                         c, got, b3.dmem_resp_valid, b3.dmem_req_ready, e);
            end
            @(negedge clk);
        end
        b3.dmem_resp_ready = 1'b1;
        @(posedge clk); #1;
        n_assert++;
        if (b3.dmem_resp_valid !== 1'b0 || b3.dmem_req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL lat3_release got valid=%b req_ready=%b expected 0 1",
                     b3.dmem_resp_valid, b3.dmem_req_ready);
        end
    endtask

    task automatic test_reset_during_store();
        logic [64:0] got, e;
        int lat;
        @(negedge clk);
        b0.dmem_req_addr  = 64'h8000_0008;
        b0.dmem_req_wdata = 64'h5555_AAAA_5555_AAAA;
        b0.dmem_req_size  = 2'd3;
        b0.dmem_req_wen   = 1'b1;
        b0.dmem_req_valid = 1'b1;
        @(posedge clk); #1;
        b0.dmem_req_valid = 1'b0;
        n_assert++;
        if (b0.sim_dwen !== 1'b1) begin
            n_fail++; $display("FAIL abort_store_access got dwen=%b expected 1", b0.sim_dwen);
        end
        reset_n = 1'b0;
        #1;
        n_assert++;
        if ({b0.sim_dwen, b0.dmem_req_ready, b0.dmem_resp_valid} !== 3'b000 || b0.sim_dmask !== '0) begin
            n_fail++;
            $display("FAIL abort_drop got dwen=%b ready=%b valid=%b dmask=%h expected all 0",
                     b0.sim_dwen, b0.dmem_req_ready, b0.dmem_resp_valid, b0.sim_dmask);
        end
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        n_assert++;
        if (b0.dmem_req_ready !== 1'b1 || b0.dmem_resp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_idle got ready=%b valid=%b expected 1 0",
                     b0.dmem_req_ready, b0.dmem_resp_valid);
        end
        n_assert++;
        if (mem0[1] !== 64'h1122_3344_5566_7788) begin
            n_fail++; $display("FAIL abort_mem got %h expected 1122334455667788", mem0[1]);
        end
        d_send(64'h8000_0008, 64'd0, 2'd3, 1'b0);
        exp_d.push_back({1'b0, 64'h1122_3344_5566_7788});
        d_recv(got, lat);
        e = exp_d.pop_front();
        n_assert++;
        if (got !== e) begin n_fail++; $display("FAIL abort_reload got %h expected %h", got, e); end
    endtask

    initial begin
        reset_n = 1'b0;
        b0.imem_req_valid = 1'b0; b0.imem_req_addr = '0; b0.imem_resp_ready = 1'b1;
        b0.dmem_req_valid = 1'b0; b0.dmem_req_addr = '0; b0.dmem_req_wdata = '0;
        b0.dmem_req_size  = '0;   b0.dmem_req_wen  = 1'b0; b0.dmem_resp_ready = 1'b1;
        b3.imem_req_valid = 1'b0; b3.imem_req_addr = '0; b3.imem_resp_ready = 1'b1;
        b3.dmem_req_valid = 1'b0; b3.dmem_req_addr = '0; b3.dmem_req_wdata = '0;
        b3.dmem_req_size  = '0;   b3.dmem_req_wen  = 1'b0; b3.dmem_resp_ready = 1'b1;
        for (int i = 0; i < 64; i++) begin
            mem0[i] <= '0;
            mem3[i] <= '0;
        end
        mem0[0]  <= 64'hCAFE_BABE_DEAD_BEEF;
        mem3[32] <= 64'h0123_4567_89AB_CDEF;

        test_reset();
        test_store_load();
        test_byte_store();
        test_misaligned();
        test_concurrent();
        test_latency();
        test_reset_during_store();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
